// File: rtl/draw_pkg.sv
// Shared types and constants for the draw command sequencer.
package draw_pkg;

  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [6:0] SCREEN_H = 7'd120;

  typedef enum logic [1:0] {
    SHAPE_CLEAR    = 2'd0,
    SHAPE_CIRCLE   = 2'd1,
    SHAPE_REULEAUX = 2'd2,
    SHAPE_RSVD     = 2'd3
  } shape_t;

  typedef struct packed {
    shape_t      shape;
    logic [2:0]  colour;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [7:0]  size;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_RELEASE
  } seq_state_t;

  // Engine start vector for a shape; the reserved shape maps to no engine.
  function automatic logic [2:0] shape_onehot(input shape_t s);
    logic [2:0] oh;
    oh = '0;
    case (s)
      SHAPE_CLEAR:    oh = 3'b001;
      SHAPE_CIRCLE:   oh = 3'b010;
      SHAPE_REULEAUX: oh = 3'b100;
      default:        oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Command queue: power-of-two depth circular buffer of cmd_t entries.
// Full is judged on the current count only, so a pop in the same cycle
// does not make room for a push.
module draw_cmd_fifo
  import draw_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  cmd_t data_i,
  input  logic pop_i,
  output cmd_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Occupancy next-state; simultaneous push and pop leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/draw_sequencer.sv
// Draw command sequencer: queues draw commands and runs them one at a time
// on the fill / circle / reuleaux engines, muxing the active engine's pixel
// bus onto the VGA write port.
// Optional macro DRAW_SEQ_CLIP_EN suppresses plots outside the 160x120 screen.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_shape,
  input  logic [2:0]  cmd_colour,
  input  logic [7:0]  cmd_x,
  input  logic [6:0]  cmd_y,
  input  logic [7:0]  cmd_size,
  output logic [2:0]  eng_start,
  output logic [2:0]  eng_colour,
  output logic [7:0]  eng_cx,
  output logic [6:0]  eng_cy,
  output logic [7:0]  eng_size,
  input  logic [2:0]  eng_done,
  input  logic [23:0] eng_vga_x,
  input  logic [20:0] eng_vga_y,
  input  logic [8:0]  eng_vga_colour,
  input  logic [2:0]  eng_vga_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy
);

  seq_state_t state_q;
  logic [1:0] sel_q;
  logic [2:0] start_q, colour_q;
  logic [7:0] cx_q, size_q;
  logic [6:0] cy_q;

  cmd_t in_cmd, head;
  logic fifo_full, fifo_empty, pop;

  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_c;
  logic       pix_plot, done_sel, on_screen;

  assign in_cmd = '{shape: shape_t'(cmd_shape), colour: cmd_colour,
                    x: cmd_x, y: cmd_y, size: cmd_size};
  assign pop    = (state_q == ST_LAUNCH);

  draw_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid),
    .data_i  (in_cmd),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Select the active engine's pixel bus and done bit; other engines are ignored.
  always_comb begin
    pix_x    = '0;
    pix_y    = '0;
    pix_c    = '0;
    pix_plot = 1'b0;
    done_sel = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sel_q == 2'(i)) begin
        pix_x    = eng_vga_x[8*i +: 8];
        pix_y    = eng_vga_y[7*i +: 7];
        pix_c    = eng_vga_colour[3*i +: 3];
        pix_plot = eng_vga_plot[i];
        done_sel = eng_done[i];
      end
    end
  end

`ifdef DRAW_SEQ_CLIP_EN
  assign on_screen = (pix_x < SCREEN_W) && (pix_y < SCREEN_H);
`else
  assign on_screen = 1'b1;
`endif

  // Sequencer FSM: launch queued commands in order, hold start through RUN,
  // then wait for the engine to drop done before taking the next command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      start_q  <= '0;
      colour_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      size_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_q <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          sel_q    <= head.shape;
          colour_q <= head.colour;
          cx_q     <= head.x;
          cy_q     <= head.y;
          size_q   <= head.size;
          if (head.shape == SHAPE_RSVD) begin
            state_q <= ST_IDLE;
          end else begin
            start_q <= shape_onehot(head.shape);
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (done_sel) begin
            start_q <= '0;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!done_sel) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = !fifo_full;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign eng_start  = start_q;
  assign eng_colour = colour_q;
  assign eng_cx     = cx_q;
  assign eng_cy     = cy_q;
  assign eng_size   = size_q;
  assign vga_x      = pix_x;
  assign vga_y      = pix_y;
  assign vga_colour = pix_c;
  assign vga_plot   = (state_q == ST_RUN) && pix_plot && on_screen;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: directed command sequences, with every engine
// launch checked against a queue of expected launches by a separate monitor.
module tb_draw_sequencer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cmd_valid, cmd_ready;
  logic [1:0]  cmd_shape;
  logic [2:0]  cmd_colour;
  logic [7:0]  cmd_x, cmd_size;
  logic [6:0]  cmd_y;
  logic [2:0]  eng_start, eng_colour, eng_done;
  logic [7:0]  eng_cx, eng_size;
  logic [6:0]  eng_cy;
  logic [23:0] eng_vga_x;
  logic [20:0] eng_vga_y;
  logic [8:0]  eng_vga_colour;
  logic [2:0]  eng_vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy;

  logic       auto_en;
  logic [2:0] auto_done, man_done;
  assign eng_done = auto_en ? auto_done : man_done;

  typedef struct {
    logic [2:0] start;
    logic [2:0] colour;
    logic [7:0] cx;
    logic [6:0] cy;
    logic [7:0] size;
  } launch_t;

  launch_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  draw_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_shape(cmd_shape), .cmd_colour(cmd_colour), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_size(cmd_size), .eng_start(eng_start), .eng_colour(eng_colour),
    .eng_cx(eng_cx), .eng_cy(eng_cy), .eng_size(eng_size), .eng_done(eng_done),
    .eng_vga_x(eng_vga_x), .eng_vga_y(eng_vga_y), .eng_vga_colour(eng_vga_colour),
    .eng_vga_plot(eng_vga_plot), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [1:0] s, input logic [2:0] c, input logic [7:0] x,
                         input logic [6:0] y, input logic [7:0] sz);
    cmd_shape = s; cmd_colour = c; cmd_x = x; cmd_y = y; cmd_size = sz;
  endtask

  task automatic send(input logic [1:0] s, input logic [2:0] c, input logic [7:0] x,
                      input logic [6:0] y, input logic [7:0] sz);
    int n;
    set_cmd(s, c, x, y, sz);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input string name, input logic [2:0] exp, input int budget);
    int n;
    n = 0;
    while (eng_start !== exp && n < budget) begin
      tick();
      n++;
    end
    chk(name, eng_start, exp);
  endtask

  // Simple engine model: done follows start one cycle later.
  initial begin
    auto_done = '0;
    forever begin
      @(posedge clk);
      #2;
      auto_done = eng_start;
    end
  end

  // Monitor: every rising start is matched against the next expected launch.
  initial begin
    logic [2:0] prev;
    launch_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && eng_start != 3'b000 && prev == 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_start", eng_start, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_start", eng_start, e.start);
          chk("sb_colour", eng_colour, e.colour);
          chk("sb_cx", eng_cx, e.cx);
          chk("sb_cy", eng_cy, e.cy);
          chk("sb_size", eng_size, e.size);
        end
      end
      prev = eng_start;
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  typedef struct { logic [7:0] x; logic [6:0] y; logic exp_plot; } clipv_t;

  initial begin
    clipv_t cv[5];
    logic clip;
`ifdef DRAW_SEQ_CLIP_EN
    clip = 1'b1;
`else
    clip = 1'b0;
`endif
    rst_n = 1'b0; cmd_valid = 1'b0; auto_en = 1'b0; man_done = '0;
    set_cmd(0, 0, 0, 0, 0);
    eng_vga_x = '0; eng_vga_y = '0; eng_vga_colour = '0; eng_vga_plot = '0;
    tick(); tick();

    // Reset state
    chk("rst_ready", cmd_ready, 1);
    chk("rst_start", eng_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_cx", eng_cx, 0);
    chk("rst_size", eng_size, 0);
    rst_n = 1'b1;
    tick();

    // Circle launch latency and parameters
    exp_q.push_back('{3'b010, 3'd2, 8'd80, 7'd60, 8'd40});
    set_cmd(1, 2, 80, 60, 40);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("c1_busy_after_push", busy, 1);
    chk("c1_start_e0", eng_start, 0);
    tick();
    chk("c1_start_e1", eng_start, 0);
    tick();
    chk("c1_start_e2", eng_start, 3'b010);
    chk("c1_cx", eng_cx, 80);
    chk("c1_cy", eng_cy, 60);
    chk("c1_size", eng_size, 40);

    // Pixel mux follows engine 1 only
    eng_vga_x = {8'd0, 8'd10, 8'd99};
    eng_vga_y = {7'd0, 7'd20, 7'd77};
    eng_vga_colour = {3'd0, 3'd6, 3'd1};
    eng_vga_plot = 3'b011;
    #1;
    chk("pix_x", vga_x, 10);
    chk("pix_y", vga_y, 20);
    chk("pix_colour", vga_colour, 6);
    chk("pix_plot", vga_plot, 1);
    eng_vga_plot = 3'b001;
    #1;
    chk("pix_plot_other_engine", vga_plot, 0);
    eng_vga_plot = 3'b011;
    man_done = 3'b101;
    tick();
    chk("done_other_ignored", eng_start, 3'b010);
    man_done = 3'b010;
    tick();
    chk("done_start_drop", eng_start, 0);
    chk("release_busy", busy, 1);
    chk("release_plot", vga_plot, 0);
    man_done = '0;
    tick();
    chk("idle_busy", busy, 0);
    eng_vga_plot = '0;

    // Queue fill behind a busy engine
    exp_q.push_back('{3'b010, 3'd3, 8'd1, 7'd2, 8'd3});
    send(1, 3, 1, 2, 3);
    wait_start("fill_first_start", 3'b010, 5);
    exp_q.push_back('{3'b001, 3'd1, 8'd11, 7'd12, 8'd13});
    exp_q.push_back('{3'b100, 3'd3, 8'd21, 7'd22, 8'd23});
    exp_q.push_back('{3'b010, 3'd4, 8'd31, 7'd32, 8'd33});
    exp_q.push_back('{3'b001, 3'd7, 8'd41, 7'd42, 8'd43});
    exp_q.push_back('{3'b100, 3'd5, 8'd51, 7'd52, 8'd53});
    cmd_valid = 1'b1;
    set_cmd(0, 1, 11, 12, 13); tick();
    set_cmd(2, 3, 21, 22, 23); tick();
    set_cmd(1, 4, 31, 32, 33); tick();
    set_cmd(0, 7, 41, 42, 43); tick();
    chk("fill_ready_full", cmd_ready, 0);
    set_cmd(2, 5, 51, 52, 53);
    tick(); tick(); tick();
    chk("fill_ready_held", cmd_ready, 0);
    man_done = 3'b010; tick();
    man_done = '0; tick();
    tick();
    chk("fill_ready_launch", cmd_ready, 0);
    tick();
    chk("fill_ready_after_pop", cmd_ready, 1);
    chk("fill_next_start", eng_start, 3'b001);
    tick();
    cmd_valid = 1'b0;
    chk("fill_ready_refull", cmd_ready, 0);
    auto_en = 1'b1;
    for (int i = 0; i < 100 && busy; i++) tick();
    chk("fill_drain_busy", busy, 0);
    auto_en = 1'b0;

    // Reserved shape dropped, reuleaux runs; clipping on engine 2
    set_cmd(3, 1, 9, 9, 9);
    cmd_valid = 1'b1;
    tick();
    exp_q.push_back('{3'b100, 3'd5, 8'd30, 7'd40, 8'd50});
    set_cmd(2, 5, 30, 40, 50);
    tick();
    cmd_valid = 1'b0;
    chk("rsv_start_e1", eng_start, 0);
    tick();
    chk("rsv_start_e2", eng_start, 0);
    chk("rsv_busy", busy, 1);
    tick();
    chk("rsv_start_e3", eng_start, 0);
    tick();
    chk("reu_start", eng_start, 3'b100);
    chk("reu_cx", eng_cx, 30);
    cv[0] = '{8'd165, 7'd14, !clip};
    cv[1] = '{8'd160, 7'd14, !clip};
    cv[2] = '{8'd159, 7'd14, 1'b1};
    cv[3] = '{8'd10, 7'd120, !clip};
    cv[4] = '{8'd10, 7'd119, 1'b1};
    eng_vga_plot = 3'b100;
    eng_vga_colour = {3'd3, 6'd0};
    for (int i = 0; i < 5; i++) begin
      eng_vga_x = {cv[i].x, 16'd0};
      eng_vga_y = {cv[i].y, 14'd0};
      #1;
      chk("clip_plot", vga_plot, cv[i].exp_plot);
      chk("clip_x", vga_x, cv[i].x);
    end
    eng_vga_plot = '0;
    man_done = 3'b100;
    tick();
    chk("reu_done_start", eng_start, 0);
    chk("reu_release_busy", busy, 1);
    man_done = '0;
    tick();
    chk("reu_idle_busy", busy, 0);

    // Reset mid-RUN with queued commands
    exp_q.push_back('{3'b010, 3'd6, 8'd70, 7'd50, 8'd20});
    send(1, 6, 70, 50, 20);
    wait_start("rr_start", 3'b010, 5);
    send(0, 1, 1, 1, 1);
    send(2, 2, 2, 2, 2);
    chk("rr_busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("rr_start_dropped", eng_start, 0);
    chk("rr_busy", busy, 0);
    chk("rr_ready", cmd_ready, 1);
    chk("rr_cx_cleared", eng_cx, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("rr_no_later_start", eng_start, 0);
    chk("rr_still_idle", busy, 0);

    chk("sb_all_consumed", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
